// File: rtl/pll_reconfig_seq.sv
// rtl/pll_reconfig_seq.sv - PLL C-counter reconfiguration sequencer driving an Avalon-MM reconfig slave
// Optional dynamic phase-shift write step is enabled by defining PLL_RECONFIG_DPS_EN
module pll_reconfig_seq #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_MAX        = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_cnt,
    input  logic [7:0]  req_hi,
    input  logic [7:0]  req_lo,
    input  logic        req_odd,
    input  logic        req_bypass,
`ifdef PLL_RECONFIG_DPS_EN
    input  logic [15:0] req_ps_steps,
    input  logic        req_ps_up,
`endif
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [3:0] {
        IDLE,
        WR_MODE,
        WR_CNT,
`ifdef PLL_RECONFIG_DPS_EN
        WR_DPS,
`endif
        WR_START,
        RD_STAT,
        CHK_STAT,
        WAIT_LOCK,
        FINISH,
        FAIL
    } state_t;

    state_t        state;
    logic [TW-1:0] tmo;
    logic          lock_meta;
    logic          lock_sync;
    logic [4:0]    cnt_q;
    logic [7:0]    hi_q;
    logic [7:0]    lo_q;
    logic          odd_q;
    logic          byp_q;
    logic [31:0]   cnt_word;
    logic          unused_readdata;

    assign req_ready       = (state == IDLE);
    assign busy            = (state != IDLE);
    assign cnt_word        = {9'b0, cnt_q, odd_q, byp_q, hi_q, lo_q};
    assign unused_readdata = ^mgmt_readdata[31:1];

`ifdef PLL_RECONFIG_DPS_EN
    logic [15:0] steps_q;
    logic        up_q;
    logic [31:0] dps_word;
    assign dps_word = {10'b0, up_q, cnt_q, steps_q};
`endif

    // pll_locked comes from the PLL's own domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            tmo            <= '0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cnt_q          <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            odd_q          <= 1'b0;
            byp_q          <= 1'b0;
`ifdef PLL_RECONFIG_DPS_EN
            steps_q        <= '0;
            up_q           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cnt_q <= req_cnt;
                    hi_q  <= req_hi;
                    lo_q  <= req_lo;
                    odd_q <= req_odd;
                    byp_q <= req_bypass;
`ifdef PLL_RECONFIG_DPS_EN
                    steps_q <= req_ps_steps;
                    up_q    <= req_ps_up;
`endif
                    if (int'(req_cnt) > CNT_MAX) begin
                        state <= FAIL;
                        error <= 1'b1;
                    end else begin
                        state          <= WR_MODE;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= 6'd0;
                        mgmt_writedata <= 32'h0000_0001;
                    end
                end
                WR_MODE: if (!mgmt_waitrequest) begin
                    state          <= WR_CNT;
                    mgmt_address   <= 6'd5;
                    mgmt_writedata <= cnt_word;
                end
                WR_CNT: if (!mgmt_waitrequest) begin
`ifdef PLL_RECONFIG_DPS_EN
                    if (steps_q != 16'd0) begin
                        state          <= WR_DPS;
                        mgmt_address   <= 6'd6;
                        mgmt_writedata <= dps_word;
                    end else begin
                        state          <= WR_START;
                        mgmt_address   <= 6'd2;
                        mgmt_writedata <= 32'h0000_0001;
                    end
`else
                    state          <= WR_START;
                    mgmt_address   <= 6'd2;
                    mgmt_writedata <= 32'h0000_0001;
`endif
                end
`ifdef PLL_RECONFIG_DPS_EN
                WR_DPS: if (!mgmt_waitrequest) begin
                    state          <= WR_START;
                    mgmt_address   <= 6'd2;
                    mgmt_writedata <= 32'h0000_0001;
                end
`endif
                WR_START: if (!mgmt_waitrequest) begin
                    state          <= RD_STAT;
                    mgmt_write     <= 1'b0;
                    mgmt_read      <= 1'b1;
                    mgmt_address   <= 6'd1;
                    mgmt_writedata <= '0;
                    tmo            <= '0;
                end
                // Timeout overrides everything, including a read still stalled
                RD_STAT, CHK_STAT, WAIT_LOCK: begin
                    if (tmo == TMO_LAST) begin
                        state        <= FAIL;
                        error        <= 1'b1;
                        mgmt_read    <= 1'b0;
                        mgmt_address <= '0;
                    end else begin
                        tmo <= tmo + TMO_ONE;
                        case (state)
                            RD_STAT: if (!mgmt_waitrequest) begin
                                state        <= CHK_STAT;
                                mgmt_read    <= 1'b0;
                                mgmt_address <= '0;
                            end
                            CHK_STAT: if (mgmt_readdata[0]) begin
                                state <= WAIT_LOCK;
                            end else begin
                                state        <= RD_STAT;
                                mgmt_read    <= 1'b1;
                                mgmt_address <= 6'd1;
                            end
                            default: if (lock_sync) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                FAIL: begin
                    state <= IDLE;
                    error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb/tb_pll_reconfig_seq.sv - table-driven bench for pll_reconfig_seq with a stalling Avalon-MM slave model
module tb_pll_reconfig_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_cnt = '0;
    logic [7:0]  req_hi = '0;
    logic [7:0]  req_lo = '0;
    logic        req_odd = 1'b0;
    logic        req_bypass = 1'b0;
`ifdef PLL_RECONFIG_DPS_EN
    logic [15:0] req_ps_steps = '0;
    logic        req_ps_up = 1'b0;
`endif
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = '0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    pll_reconfig_seq #(.TIMEOUT_CYCLES(16), .CNT_MAX(17)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cnt(req_cnt),
        .req_hi(req_hi), .req_lo(req_lo), .req_odd(req_odd), .req_bypass(req_bypass),
`ifdef PLL_RECONFIG_DPS_EN
        .req_ps_steps(req_ps_steps), .req_ps_up(req_ps_up),
`endif
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
        .busy(busy), .done(done), .error(error)
    );

    int checks = 0;
    int failures = 0;

    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int rd_cnt = 0, a5_cycles = 0, n_done = 0, n_err = 0, overlap = 0, hold_viol = 0;
    int zero_reads = 0, stall_left = 0;
    logic [5:0]  stall_addr = 6'h3f;
    logic        prev_stall = 1'b0;
    logic [39:0] prev_cmd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Slave: stalls a chosen address, returns status bit0=1 after zero_reads reads
    always @(negedge clk) begin
        mgmt_readdata = {31'b0, (rd_cnt > zero_reads)};
        if ((mgmt_write || mgmt_read) && mgmt_address == stall_addr && stall_left > 0) begin
            mgmt_waitrequest = 1'b1;
            stall_left--;
        end else begin
            mgmt_waitrequest = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (mgmt_write && !mgmt_waitrequest) begin
                wr_addr_q.push_back(mgmt_address);
                wr_data_q.push_back(mgmt_writedata);
            end
            if (mgmt_read && !mgmt_waitrequest) rd_cnt++;
            if (mgmt_read && mgmt_write) overlap++;
            if (mgmt_write && mgmt_address == 6'd5) a5_cycles++;
            if (done) n_done++;
            if (error) n_err++;
            if (prev_stall && {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata} != prev_cmd)
                hold_viol++;
            prev_stall = (mgmt_write || mgmt_read) && mgmt_waitrequest;
            prev_cmd   = {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    typedef struct {
        logic [4:0]  cnt;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        odd;
        logic        byp;
        int          zr;
        int          stall_n;
        logic        exp_err;
        logic [31:0] exp_word;
        int          exp_lat;
        int          exp_reads;
    } vec_t;

    // Acceptance cycle is cycle 1; lat is the cycle in which done/error is seen
    task automatic run_req(input vec_t v, input logic [5:0] s_addr,
                           output int lat, output logic got_done, output logic got_err);
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_cnt = 0; a5_cycles = 0; n_done = 0; n_err = 0;
        zero_reads = v.zr; stall_addr = s_addr; stall_left = v.stall_n;
        req_cnt = v.cnt; req_hi = v.hi; req_lo = v.lo; req_odd = v.odd; req_bypass = v.byp;
        req_valid = 1'b1;
        chk("ready_before", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_cnt = ~v.cnt; req_hi = ~v.hi; req_lo = ~v.lo; req_odd = ~v.odd; req_bypass = ~v.byp;
        lat = 0; got_done = 1'b0; got_err = 1'b0;
        for (int c = 2; c <= 100; c++) begin
            @(negedge clk);
            if (done || error) begin
                lat = c; got_done = done; got_err = error;
                break;
            end
        end
        @(negedge clk);
        chk("pulse_one_cycle", {done, error}, 0);
        chk("ready_after", {req_ready, busy}, 2'b10);
    endtask

    vec_t vecs[6];
    int          lat;
    logic        gd, ge;
    logic [5:0]  ea[3];
    logic [31:0] ed[3];
    logic        found;

    initial begin
        vecs[0] = '{5'd2,  8'h06, 8'h06, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0008_0606, 8,  1};
        vecs[1] = '{5'd2,  8'h06, 8'h06, 1'b0, 1'b0, 0, 3, 1'b0, 32'h0008_0606, 11, 1};
        vecs[2] = '{5'd17, 8'hab, 8'h12, 1'b1, 1'b0, 4, 0, 1'b0, 32'h0046_ab12, 16, 5};
        vecs[3] = '{5'd0,  8'h01, 8'h02, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0001_0102, 8,  1};
        vecs[4] = '{5'd20, 8'h06, 8'h06, 1'b0, 1'b0, 0, 0, 1'b1, 32'h0,         2,  0};
        vecs[5] = '{5'd31, 8'hff, 8'hff, 1'b1, 1'b1, 0, 0, 1'b1, 32'h0,         2,  0};

        repeat (3) @(negedge clk);
        chk("reset_strobes", {mgmt_write, mgmt_read, done, error, busy}, 0);
        chk("reset_addr_data", {mgmt_address, mgmt_writedata}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {req_ready, busy}, 2'b10);

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i], 6'd5, lat, gd, ge);
            chk($sformatf("v%0d_result", i), {gd, ge}, {~vecs[i].exp_err, vecs[i].exp_err});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_writes", i), wr_addr_q.size(), vecs[i].exp_err ? 0 : 3);
            chk($sformatf("v%0d_reads", i), rd_cnt, vecs[i].exp_reads);
            chk($sformatf("v%0d_addr5_cycles", i), a5_cycles, vecs[i].exp_err ? 0 : vecs[i].stall_n + 1);
            ea = '{6'd0, 6'd5, 6'd2};
            ed = '{32'h1, vecs[i].exp_word, 32'h1};
            if (wr_addr_q.size() == 3) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("v%0d_wr%0d_addr", i, k), wr_addr_q[k], ea[k]);
                    chk($sformatf("v%0d_wr%0d_data", i, k), wr_data_q[k], ed[k]);
                end
            end
        end

        // Lock held low: polling succeeds but WAIT_LOCK runs into the timeout
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        run_req(vecs[0], 6'h3f, lat, gd, ge);
        chk("tmo_result", {gd, ge}, 2'b01);
        chk("tmo_latency", lat, 21);
        chk("tmo_done_count", n_done, 0);
        chk("tmo_reads", rd_cnt, 1);
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);

        // Reset while WR_START is stalled
        stall_addr = 6'd2; stall_left = 20; n_done = 0; n_err = 0;
        req_cnt = 5'd2; req_hi = 8'h06; req_lo = 8'h06; req_odd = 1'b0; req_bypass = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mgmt_write && mgmt_address == 6'd2 && mgmt_waitrequest) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_reached_start", found, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_strobes", {mgmt_write, mgmt_read, busy, done, error}, 0);
        chk("rst_async_addr", mgmt_address, 0);
        @(negedge clk);
        stall_left = 0;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_pulse", n_done + n_err, 0);
        chk("rst_idle", {req_ready, busy}, 2'b10);

`ifdef PLL_RECONFIG_DPS_EN
        req_ps_steps = 16'd5;
        req_ps_up = 1'b1;
        run_req('{5'd1, 8'h00, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0004_0000, 9, 1}, 6'h3f, lat, gd, ge);
        req_ps_steps = 16'd0;
        req_ps_up = 1'b0;
        chk("dps_result", {gd, ge}, 2'b10);
        chk("dps_latency", lat, 9);
        chk("dps_writes", wr_addr_q.size(), 4);
        if (wr_addr_q.size() == 4) begin
            chk("dps_wr1_addr", wr_addr_q[1], 6'd5);
            chk("dps_wr2_addr", wr_addr_q[2], 6'd6);
            chk("dps_wr2_data", wr_data_q[2], 32'h0021_0005);
            chk("dps_wr3_addr", wr_addr_q[3], 6'd2);
        end
`endif

        chk("no_rd_wr_overlap", overlap, 0);
        chk("stall_hold_stable", hold_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
